// File: rtl/irc_pkg.sv
// ---------------------------------------------------------------------------
// irc_pkg
// Shared definitions for the IR/UART transmit path:
//   - irc_state_e          : serialiser FSM state encodings
//   - C_UART_DATA_BITS     : data bits per UART frame
//   - irc_carrier_half_period(clk_hz, carrier_hz) : carrier half-period in
//                            clock cycles, rounded to nearest
// ---------------------------------------------------------------------------
package irc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } irc_state_e;

  localparam int C_UART_DATA_BITS = 8;

  // Rounded clk_hz / (2 * carrier_hz): adding carrier_hz (half the divisor)
  // before the integer divide rounds to nearest.
  function automatic int irc_carrier_half_period(input int clk_hz, input int carrier_hz);
    return (clk_hz + carrier_hz) / (32'sd2 * carrier_hz);
  endfunction

endpackage

// File: rtl/irc_carrier_gen.sv
// ---------------------------------------------------------------------------
// irc_carrier_gen
// Free-running square-wave generator for the IR carrier. A counter runs
// 0..H-1 and the carrier output toggles every time it wraps, so one full
// carrier period is 2*H clock cycles. Runs continuously after reset.
// Ports:
//   aclk     in  clock
//   aresetn  in  synchronous active-low reset
//   carrier  out carrier square wave, registered, 0 after reset
// ---------------------------------------------------------------------------
module irc_carrier_gen
  import irc_pkg::*;
#(
  parameter int C_CLK_HZ     = 125000000,
  parameter int C_CARRIER_HZ = 38000
) (
  input  logic aclk,
  input  logic aresetn,
  output logic carrier
);

  localparam int H = irc_carrier_half_period(C_CLK_HZ, C_CARRIER_HZ);
  localparam int W = (H > 1) ? $clog2(H) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(H - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         carrier_q, carrier_d;

  // Divider counter and carrier toggle.
  always_comb begin
    cnt_d     = cnt_q;
    carrier_d = carrier_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d     = {W{1'b0}};
      carrier_d = ~carrier_q;
    end else begin
      cnt_d     = cnt_q + W'(1);
    end
  end

  // Divider state register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q     <= {W{1'b0}};
      carrier_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      carrier_q <= carrier_d;
    end
  end

  assign carrier = carrier_q;

endmodule

// File: rtl/irc_uart_tx.sv
// ---------------------------------------------------------------------------
// irc_uart_tx
// AXI4-stream byte serialiser. Each accepted byte is sent as a UART frame
// (start, 8 data bits LSB first, [even parity], stop) with every bit held
// for M = mod_m clock cycles (M=0 treated as 1). ir_out follows tx_line one
// cycle later, optionally gating the space bits with the IR carrier.
// Optional feature macro: IRC_TX_PARITY_EN (adds an even-parity bit).
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axis_tdata/tvalid      byte input stream
//   s_axis_tready            high only while idle
//   mod_m                    cycles per bit, latched with each byte
//   mod_38khz_en             carrier-modulate spaces on ir_out (live)
//   tx_line                  UART line, idle high, registered
//   ir_out                   LED drive, registered, 1 cycle after tx_line
//   busy                     frame in progress, registered
// ---------------------------------------------------------------------------
module irc_uart_tx
  import irc_pkg::*;
#(
  parameter int C_CLK_HZ     = 125000000,
  parameter int C_CARRIER_HZ = 38000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [15:0] mod_m,
  input  logic        mod_38khz_en,
  output logic        tx_line,
  output logic        ir_out,
  output logic        busy
);

  localparam logic [2:0] LAST_IDX = 3'(C_UART_DATA_BITS - 1);

  irc_state_e                  state_q, state_d;
  logic [15:0]                 baud_q, baud_d;
  logic [2:0]                  idx_q, idx_d;
  logic [C_UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [15:0]                 m_q, m_d;
  logic                        tx_line_q, tx_line_d;
  logic                        ir_out_q, ir_out_d;
  logic                        busy_q, busy_d;
  logic                        tready_q, tready_d;
`ifdef IRC_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif
  logic                        carrier_s;
  logic                        bit_end_s;

  irc_carrier_gen #(
    .C_CLK_HZ     (C_CLK_HZ),
    .C_CARRIER_HZ (C_CARRIER_HZ)
  ) u_carrier (
    .aclk    (aclk),
    .aresetn (aresetn),
    .carrier (carrier_s)
  );

  // Last cycle of the current bit; m_q is at least 1 whenever a bit state is active.
  assign bit_end_s = (baud_q == (m_q - 16'd1));

  // State, counter, data and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= '0;
      m_q       <= 16'd0;
      tx_line_q <= 1'b1;
      ir_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      tready_q  <= 1'b1;
`ifdef IRC_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      m_q       <= m_d;
      tx_line_q <= tx_line_d;
      ir_out_q  <= ir_out_d;
      busy_q    <= busy_d;
      tready_q  <= tready_d;
`ifdef IRC_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) state_d = S_START;
        else               state_d = S_IDLE;
      end
      S_START: begin
        if (bit_end_s) state_d = S_DATA;
        else           state_d = S_START;
      end
      S_DATA: begin
        if (bit_end_s && (idx_q == LAST_IDX)) begin
`ifdef IRC_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IRC_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) state_d = S_STOP;
        else           state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (bit_end_s) state_d = S_IDLE;
        else           state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: byte/M capture on handshake, baud counter, bit index and shifter.
  always_comb begin
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    m_d     = m_q;
`ifdef IRC_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == S_IDLE) begin
      baud_d = 16'd0;
      idx_d  = 3'd0;
      if (s_axis_tvalid) begin
        shift_d = s_axis_tdata;
        m_d     = (mod_m == 16'd0) ? 16'd1 : mod_m;
`ifdef IRC_TX_PARITY_EN
        parity_d = ^s_axis_tdata;
`endif
      end else begin
        shift_d = shift_q;
      end
    end else if (bit_end_s) begin
      baud_d = 16'd0;
      if (state_q == S_DATA) begin
        // Index wraps 7 -> 0 on the last data bit.
        idx_d   = idx_q + 3'd1;
        shift_d = {1'b0, shift_q[C_UART_DATA_BITS-1:1]};
      end else begin
        idx_d   = idx_q;
      end
    end else begin
      baud_d = baud_q + 16'd1;
    end
  end

  // Outputs, computed from the next state so registered outputs line up with the state.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    tready_d = (state_d == S_IDLE);
    case (state_d)
      S_IDLE:   tx_line_d = 1'b1;
      S_START:  tx_line_d = 1'b0;
      S_DATA:   tx_line_d = shift_d[0];
`ifdef IRC_TX_PARITY_EN
      S_PARITY: tx_line_d = parity_q;
`endif
      S_STOP:   tx_line_d = 1'b1;
      default:  tx_line_d = 1'b1;
    endcase
    // Carrier bursts on spaces, dark on marks and idle.
    if (mod_38khz_en) ir_out_d = ~tx_line_q & carrier_s;
    else              ir_out_d = tx_line_q;
  end

  assign tx_line       = tx_line_q;
  assign ir_out        = ir_out_q;
  assign busy          = busy_q;
  assign s_axis_tready = tready_q;

endmodule
